// File: rtl/fios_operand_port.sv
// Operand/result staging port for a FIOS Montgomery multiplier: host-loaded A/B/P
// word arrays streamed to the multiplier on request, result words captured into R.
module fios_operand_port #(
  parameter int s     = 8,
  parameter int PE_NB = 8
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic                  load_en_i,
  input  logic [1:0]            load_sel_i,
  input  logic [$clog2(s)-1:0]  load_addr_i,
  input  logic [16:0]           load_data_i,
  input  logic                  go_i,
  output logic                  start_o,
  input  logic                  a_shift_i,
  input  logic                  b_fetch_i,
  input  logic                  p_fetch_i,
  input  logic                  RES_push_i,
  input  logic                  done_i,
  output logic [PE_NB*17-1:0]   a_o,
  output logic [16:0]           b_o,
  output logic [16:0]           p_o,
  input  logic [16:0]           RES_i,
  input  logic [$clog2(s)-1:0]  rd_addr_i,
  output logic [16:0]           rd_data_o,
  output logic                  busy_o,
  output logic                  res_valid_o,
  output logic                  err_o
);

  localparam int AW  = $clog2(s);
  localparam int RW  = $clog2(s + 1);
  localparam int NA  = (s + PE_NB - 1) / PE_NB;
  localparam int AIW = $clog2(NA + 1);

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  state_t          r_state;
  logic            r_start;
  logic            r_busy;
  logic            r_res_valid;
  logic            r_err;
  logic [AIW-1:0]  r_a_idx;
  logic [AW-1:0]   r_b_idx;
  logic [AW-1:0]   r_p_idx;
  logic [RW-1:0]   r_r_idx;
  logic [16:0]     r_b_o;
  logic [16:0]     r_p_o;
  logic [16:0]     r_rd_data;

  logic [16:0] r_a_mem [s];
  logic [16:0] r_b_mem [s];
  logic [16:0] r_p_mem [s];
  logic [16:0] r_r_mem [s];

  logic          w_run;
  logic          w_load_ok;
  logic          w_push_ok;
  logic [RW-1:0] w_r_after;

  assign w_run     = (r_state == RUN);
  assign w_load_ok = load_en_i && (r_state == IDLE || r_state == DONE) &&
                     (load_sel_i != 2'd3) && (32'(load_addr_i) < 32'(s));
  assign w_push_ok = w_run && RES_push_i && (r_r_idx < RW'(s));
  // r_idx as it will stand after this edge, so done_i sees a same-cycle push
  assign w_r_after = r_r_idx + RW'(w_push_ok);

  // Word arrays carry no reset so they can map onto plain storage.
  always_ff @(posedge clock_i) begin
    if (w_load_ok) begin
      case (load_sel_i)
        2'd0:    r_a_mem[load_addr_i] <= load_data_i;
        2'd1:    r_b_mem[load_addr_i] <= load_data_i;
        2'd2:    r_p_mem[load_addr_i] <= load_data_i;
        default: ;
      endcase
    end
    if (w_push_ok) begin
      r_r_mem[r_r_idx[AW-1:0]] <= RES_i;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= IDLE;
      r_start     <= 1'b0;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_err       <= 1'b0;
      r_a_idx     <= '0;
      r_b_idx     <= '0;
      r_p_idx     <= '0;
      r_r_idx     <= '0;
      r_b_o       <= '0;
      r_p_o       <= '0;
      r_rd_data   <= '0;
    end else begin
      r_rd_data <= (32'(rd_addr_i) < 32'(s)) ? r_r_mem[rd_addr_i] : 17'd0;
      case (r_state)
        IDLE, DONE: begin
          if (go_i) begin
            r_state     <= START;
            r_start     <= 1'b1;
            r_busy      <= 1'b1;
            r_res_valid <= 1'b0;
            r_err       <= 1'b0;
            r_a_idx     <= '0;
            r_b_idx     <= '0;
            r_p_idx     <= '0;
            r_r_idx     <= '0;
          end
        end
        START: begin
          r_state <= RUN;
          r_start <= 1'b0;
        end
        RUN: begin
          if (a_shift_i && (r_a_idx < AIW'(NA))) begin
            r_a_idx <= r_a_idx + AIW'(1);
          end
          if (b_fetch_i) begin
            r_b_o   <= r_b_mem[r_b_idx];
            r_b_idx <= (r_b_idx == AW'(s - 1)) ? '0 : r_b_idx + AW'(1);
          end
          if (p_fetch_i) begin
            r_p_o   <= r_p_mem[r_p_idx];
            r_p_idx <= (r_p_idx == AW'(s - 1)) ? '0 : r_p_idx + AW'(1);
          end
          if (w_push_ok) begin
            r_r_idx <= w_r_after;
          end else if (RES_push_i) begin
            r_err <= 1'b1;
          end
          if (done_i) begin
            r_state     <= DONE;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b1;
            if (w_r_after != RW'(s)) begin
              r_err <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Words past the end of A read as zero so a partial last group is padded.
  for (genvar gi = 0; gi < PE_NB; gi++) begin : g_a_word
    logic [31:0] w_idx;
    assign w_idx = 32'(r_a_idx) * 32'(PE_NB) + 32'(gi);
    assign a_o[gi*17 +: 17] = (w_idx < 32'(s)) ? r_a_mem[w_idx[AW-1:0]] : 17'd0;
  end

  assign start_o     = r_start;
  assign busy_o      = r_busy;
  assign res_valid_o = r_res_valid;
  assign err_o       = r_err;
  assign b_o         = r_b_o;
  assign p_o         = r_p_o;
  assign rd_data_o   = r_rd_data;

endmodule

// File: tb/tb_fios_operand_port.sv
// Directed bench for fios_operand_port: a PE_NB=8 and a PE_NB=3 instance share all inputs.
module tb_fios_operand_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_en;
  logic [1:0]  load_sel;
  logic [2:0]  load_addr;
  logic [16:0] load_data;
  logic        go;
  logic        a_shift, b_fetch, p_fetch, res_push, done;
  logic [16:0] res_in;
  logic [2:0]  rd_addr;

  logic         start8, busy8, rv8, err8, start3, busy3, rv3, err3;
  logic [135:0] a8;
  logic [50:0]  a3;
  logic [16:0]  b8, p8, rd8, b3, p3, rd3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fios_operand_port #(.s(8), .PE_NB(8)) dut8 (
    .clock_i(clk), .reset_n_i(rst_n), .load_en_i(load_en), .load_sel_i(load_sel),
    .load_addr_i(load_addr), .load_data_i(load_data), .go_i(go), .start_o(start8),
    .a_shift_i(a_shift), .b_fetch_i(b_fetch), .p_fetch_i(p_fetch), .RES_push_i(res_push),
    .done_i(done), .a_o(a8), .b_o(b8), .p_o(p8), .RES_i(res_in), .rd_addr_i(rd_addr),
    .rd_data_o(rd8), .busy_o(busy8), .res_valid_o(rv8), .err_o(err8));

  fios_operand_port #(.s(8), .PE_NB(3)) dut3 (
    .clock_i(clk), .reset_n_i(rst_n), .load_en_i(load_en), .load_sel_i(load_sel),
    .load_addr_i(load_addr), .load_data_i(load_data), .go_i(go), .start_o(start3),
    .a_shift_i(a_shift), .b_fetch_i(b_fetch), .p_fetch_i(p_fetch), .RES_push_i(res_push),
    .done_i(done), .a_o(a3), .b_o(b3), .p_o(p3), .RES_i(res_in), .rd_addr_i(rd_addr),
    .rd_data_o(rd3), .busy_o(busy3), .res_valid_o(rv3), .err_o(err3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [1:0] sel, input logic [2:0] addr, input logic [16:0] data);
    load_en = 1'b1; load_sel = sel; load_addr = addr; load_data = data;
    tick();
    load_en = 1'b0;
  endtask

  task automatic start_run();
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
  endtask

  task automatic read_r(input string tag, input logic [2:0] addr, input logic [16:0] exp);
    rd_addr = addr;
    tick();
    check(tag, 64'(rd8), 64'(exp));
    $display("read R[%0d] -> %05h", addr, rd8);
  endtask

  initial begin
    rst_n = 1'b1; load_en = 1'b0; load_sel = '0; load_addr = '0; load_data = '0;
    go = 1'b0; a_shift = 1'b0; b_fetch = 1'b0; p_fetch = 1'b0; res_push = 1'b0;
    done = 1'b0; res_in = '0; rd_addr = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(busy8), 64'(0));
    check("rst_start", 64'(start8), 64'(0));
    check("rst_rv_err", 64'({rv8, err8}), 64'(0));
    check("rst_bp", 64'({b8, p8}), 64'(0));
    check("rst_rd", 64'(rd8), 64'(0));
    tick(); tick();
    rst_n = 1'b1;

    for (int k = 0; k < 8; k++) begin
      load(2'd0, 3'(k), 17'(k + 1));
      load(2'd1, 3'(k), 17'(32'h100 + k));
      load(2'd2, 3'(k), 17'(32'h200 + k));
      load(2'd3, 3'(k), 17'h1ABCD);
    end
    check("a8_word3", 64'(a8[3*17 +: 17]), 64'(4));
    check("a3_group0", 64'(a3), 64'({17'd3, 17'd2, 17'd1}));

    go = 1'b1;
    check("start_before", 64'(start8), 64'(0));
    tick();
    go = 1'b0;
    check("start_pulse", 64'(start8), 64'(1));
    check("busy_start", 64'(busy8), 64'(1));
    $display("go -> start_o=%0b busy_o=%0b", start8, busy8);
    tick();
    check("start_low_run", 64'(start8), 64'(0));
    check("busy_run", 64'(busy8), 64'(1));

    // B[0] write attempt while running must be dropped
    load(2'd1, 3'd0, 17'h1FFFF);

    for (int k = 0; k < 10; k++) begin
      b_fetch = 1'b1;
      p_fetch = (k < 2);
      tick();
      b_fetch = 1'b0; p_fetch = 1'b0;
      check($sformatf("b_fetch%0d", k), 64'(b8), 64'(32'h100 + (k % 8)));
      $display("b_fetch %0d -> b_o=%05h p_o=%05h", k, b8, p8);
      if (k < 2) check($sformatf("p_fetch%0d", k), 64'(p8), 64'(32'h200 + k));
    end
    check("p_held", 64'(p8), 64'(32'h201));

    a_shift = 1'b1;
    tick();
    check("a8_sat_word0", 64'(a8[16:0]), 64'(0));
    check("a3_shift1", 64'(a3), 64'({17'd6, 17'd5, 17'd4}));
    $display("a_shift 1 -> a3=%013h", a3);
    tick();
    check("a3_shift2", 64'(a3), 64'({17'd0, 17'd8, 17'd7}));
    $display("a_shift 2 -> a3=%013h", a3);
    tick();
    check("a3_shift3", 64'(a3), 64'(0));
    tick();
    a_shift = 1'b0;
    check("a3_shift4", 64'(a3), 64'(0));
    $display("a_shift 4 -> a3=%013h", a3);

    // Last push coincides with done_i: push must land before DONE
    for (int k = 0; k < 8; k++) begin
      res_push = 1'b1;
      res_in = 17'(32'h1000 + k);
      done = (k == 7);
      tick();
    end
    res_push = 1'b0; done = 1'b0;
    check("run1_rv", 64'(rv8), 64'(1));
    check("run1_err", 64'(err8), 64'(0));
    check("run1_busy", 64'(busy8), 64'(0));
    read_r("rd5", 3'd5, 17'h1005);
    read_r("rd7", 3'd7, 17'h1007);

    start_run();
    check("run2_rv_clr", 64'(rv8), 64'(0));
    for (int k = 0; k < 9; k++) begin
      res_push = 1'b1;
      res_in = (k < 8) ? 17'(32'h2000 + k) : 17'h3000;
      tick();
      if (k == 7) check("run2_err_before", 64'(err8), 64'(0));
    end
    res_push = 1'b0;
    check("run2_err_overflow", 64'(err8), 64'(1));
    done = 1'b1;
    tick();
    done = 1'b0;
    check("run2_rv", 64'(rv8), 64'(1));
    check("run2_err_sticky", 64'(err8), 64'(1));
    read_r("run2_rd0", 3'd0, 17'h2000);
    read_r("run2_rd7", 3'd7, 17'h2007);

    start_run();
    check("run3_err_clr", 64'(err8), 64'(0));
    for (int k = 0; k < 3; k++) begin
      res_push = 1'b1;
      res_in = 17'(32'h4000 + k);
      tick();
    end
    res_push = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy8), 64'(0));
    check("midrst_bp", 64'({b8, p8}), 64'(0));
    check("midrst_rd", 64'(rd8), 64'(0));
    check("midrst_a3", 64'(a3), 64'({17'd3, 17'd2, 17'd1}));
    tick();
    rst_n = 1'b1;
    tick();

    // Short run: one push then done, so r_idx != s and err_o must rise
    start_run();
    res_push = 1'b1;
    res_in = 17'h05555;
    done = 1'b1;
    tick();
    res_push = 1'b0; done = 1'b0;
    check("run4_rv", 64'(rv8), 64'(1));
    check("run4_err_short", 64'(err8), 64'(1));
    read_r("run4_rd0", 3'd0, 17'h05555);
    read_r("run4_rd1", 3'd1, 17'h4001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
